morph_filter_3x3: RTL and testbench
===================================

MORPH_FILTER_3X3 -- requirements
Module: morph_filter_3x3

Interface
REQ-001 Parameter IMG_W, default 800, active pixels per row (>=4).
REQ-002 Parameter IMG_H, default 600, active rows per frame (>=2).
REQ-003 i_clk  input  1  sole clock, rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_valid  input  1  input pixel present; consumed only when o_ready=1.
REQ-006 i_data  input  1  binary input pixel, raster order.
REQ-007 i_mode  input  2  0 majority, 1 erode, 2 dilate, 3 bypass.
REQ-008 i_thresh  input  4  majority threshold.
REQ-009 o_ready  output  1  block accepts a pixel this cycle.
REQ-010 o_valid  output  1  o_data holds a filtered pixel.
REQ-011 o_data  output  1  filtered pixel, raster order.
REQ-012 o_last  output  1  high with o_valid on the final pixel of a frame (row IMG_H-1, col IMG_W-1).

Function
REQ-013 Internal stream has IMG_W+1 positions per row; position IMG_W is a zero pad column, inserted by the block with o_ready=0 for one cycle.
REQ-014 After row IMG_H-1 pad column, block inserts a zero pad row of IMG_W+1 cycles with o_ready=0, then returns to row 0.
REQ-015 A stream position advances on (i_valid & o_ready) or on any pad cycle; nothing else advances counters or line buffers.
REQ-016 Window is 3x3 around center (r,c); neighbours outside the image read 0 (pad column serves as right pad of row r and left pad of row r+1; pad row serves as top pad of next frame).
REQ-017 Result for center (r,c) is registered and presented one cycle after stream position (r+1,c+1) advances; o_valid=1 exactly for positions with row>=1 and col>=1, giving IMG_W*IMG_H outputs per frame.
REQ-018 Majority: o_data=1 iff 9-pixel popcount > thresh; thresh >= 9 yields 0. Erode: AND of 9. Dilate: OR of 9. Bypass: center pixel.
REQ-019 i_mode and i_thresh are sampled when stream position (0,0) advances and held for the whole frame; mid-frame changes take effect next frame.
REQ-020 FSM states: FILL (row 0 and row 1 col 0, no output), RUN, EOL_PAD (one cycle), EOF_PAD (IMG_W+1 cycles); RUN->EOL_PAD at col IMG_W-1 advance; EOL_PAD->EOF_PAD if row IMG_H-1 else RUN/FILL; EOF_PAD->FILL on completion.
REQ-021 Input gaps (i_valid=0 in RUN/FILL) stall the stream; o_valid is 0 in stalled cycles.
REQ-022 Popcount is 4 bits unsigned; no overflow possible.

Reset
REQ-023 On i_rst: o_valid=0, o_data=0, o_last=0, o_ready=1, counters 0, line buffers and window zero, FSM=FILL, latched mode=0, latched thresh=6.
REQ-024 Reset mid-frame discards the partial frame; next accepted pixel is (0,0).

Configuration
REQ-025 Macro MORPH_FILTER_STATS_EN defined: extra output o_ones_count (width clog2(IMG_W*IMG_H+1)) holds count of o_data=1 outputs of the last completed frame, updated the cycle after o_last; reset 0.
REQ-026 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-027 Package morph_filter_pkg holds the mode enum (MODE_MAJ, MODE_ERODE, MODE_DILATE, MODE_BYPASS), FSM state enum and default threshold constant.
REQ-028 Sub-module morph_line_buffer: 1-bit shift delay of IMG_W+1 with enable, synchronous clear, instantiated twice.

Verification
REQ-029 IMG_W=8,IMG_H=4, all-ones frame, mode 0 thresh 6 -> 32 outputs; corners 0 (popcount 4), edges 0 (6), interior 1 (9); o_last on output 32.
REQ-030 Single 1 at (2,3), mode 2 -> ones exactly at rows 1..3, cols 2..4; mode 1 -> all zeros.
REQ-031 Continuous i_valid -> o_ready low 1 cycle after every 8 accepted pixels and 9 cycles after pixel 32; frame period 45 cycles.
REQ-032 Random i_valid gaps, mode 3 -> output stream equals input stream, 32 outputs, same order.
REQ-033 Change i_mode 0->2 at pixel 10 -> frame uses mode 0; next frame uses mode 2.
REQ-034 Assert i_rst at pixel 17, then full frame -> exactly 32 outputs matching golden model, no residue from aborted frame; with MORPH_FILTER_STATS_EN, o_ones_count matches model.

Source files
------------

// File: rtl/morph_filter_pkg.sv
// -----------------------------------------------------------------------------
// morph_filter_pkg
// Shared types and constants for the 3x3 binary morphological filter.
//   mode_e         : filter operation selected per frame
//   state_e        : stream-position FSM states of morph_filter_3x3
//   DEFAULT_THRESH : majority threshold loaded by reset
// -----------------------------------------------------------------------------
package morph_filter_pkg;

  typedef enum logic [1:0] {
    MODE_MAJ    = 2'd0,
    MODE_ERODE  = 2'd1,
    MODE_DILATE = 2'd2,
    MODE_BYPASS = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EOL_PAD = 2'd2,
    ST_EOF_PAD = 2'd3
  } state_e;

  localparam logic [3:0] DEFAULT_THRESH = 4'd6;

endpackage

// File: rtl/morph_line_buffer.sv
// -----------------------------------------------------------------------------
// morph_line_buffer
// One-bit shift delay line of DEPTH positions. Each enabled cycle pushes i_data
// in and o_data presents the bit pushed DEPTH enabled cycles earlier, i.e. the
// pixel one stream row above the current position.
// Ports:
//   i_clk   clock, rising edge
//   i_clr   synchronous clear of the whole line (active-high)
//   i_en    shift enable (stream position advances)
//   i_data  bit pushed in
//   o_data  bit delayed by DEPTH enabled cycles
// -----------------------------------------------------------------------------
module morph_line_buffer
  import morph_filter_pkg::*;
#(
  parameter int DEPTH = 801
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_data,
  output logic o_data
);

  logic [DEPTH-1:0] line_q;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      line_q <= '0;
    end else if (i_en) begin
      line_q <= {line_q[DEPTH-2:0], i_data};
    end
  end

  assign o_data = line_q[DEPTH-1];

endmodule

// File: rtl/morph_filter_3x3.sv
// -----------------------------------------------------------------------------
// morph_filter_3x3
// Streaming 3x3 binary morphological filter (majority / erode / dilate /
// bypass) over an IMG_W x IMG_H raster. The block walks an internal stream of
// IMG_W+1 positions per row plus one trailing pad row; the pad column and pad
// row are zero pixels the block inserts itself (o_ready low), so all image
// borders read as zero without any edge-detection muxing in the window.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         synchronous reset, active-high
//   i_valid       input pixel present (taken only while o_ready=1)
//   i_data        binary input pixel, raster order
//   i_mode        0 majority, 1 erode, 2 dilate, 3 bypass (latched per frame)
//   i_thresh      majority threshold (latched per frame)
//   o_ready       block accepts a pixel this cycle
//   o_valid       o_data holds a filtered pixel
//   o_data        filtered pixel, raster order
//   o_last        with o_valid on the final pixel of the frame
//   o_ones_count  (only with MORPH_FILTER_STATS_EN) number of 1 outputs in the
//                 last completed frame
//
// Configuration macro: MORPH_FILTER_STATS_EN enables o_ones_count.
// -----------------------------------------------------------------------------
module morph_filter_3x3
  import morph_filter_pkg::*;
#(
  parameter int IMG_W = 800,
  parameter int IMG_H = 600
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_data,
  input  logic [1:0] i_mode,
  input  logic [3:0] i_thresh,
  output logic       o_ready,
  output logic       o_valid,
  output logic       o_data,
  output logic       o_last
`ifdef MORPH_FILTER_STATS_EN
  ,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0] o_ones_count
`endif
);

  localparam int COL_W = $clog2(IMG_W + 1);
  localparam int ROW_W = $clog2(IMG_H + 1);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] popcount9(input logic [8:0] w);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 9; i++) begin
      n = n + 4'(w[i]);
    end
    return n;
  endfunction

  // Window bit 4 is the center pixel.
  function automatic logic filter_op(input mode_e m, input logic [3:0] th,
                                     input logic [8:0] w);
    logic r;
    case (m)
      MODE_MAJ:    r = (popcount9(w) > th);
      MODE_ERODE:  r = &w;
      MODE_DILATE: r = |w;
      default:     r = w[4];
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic             ready_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  mode_e            mode_q;
  logic [3:0]       thresh_q;

  logic col_at_last, col_at_pad, row_at_last, row_at_pad;

  assign col_at_last = (col_q == COL_W'(IMG_W - 1));
  assign col_at_pad  = (col_q == COL_W'(IMG_W));
  assign row_at_last = (row_q == ROW_W'(IMG_H - 1));
  assign row_at_pad  = (row_q == ROW_W'(IMG_H));

  // ---------------------------------------------------------------------------
  // Stage p0: stream advance, window assembly and filter decision
  // ---------------------------------------------------------------------------
  logic       pad_p0, adv_p0, pix_p0;
  logic       lb1_p0, lb2_p0;
  logic [2:0] col_new_p0;
  logic [2:0] win_a_q, win_b_q;
  logic [8:0] win_p0;
  logic       vld_p0, last_p0, res_p0;

  assign pad_p0 = (state_q == ST_EOL_PAD) || (state_q == ST_EOF_PAD);
  assign adv_p0 = (i_valid & ready_q) | pad_p0;
  assign pix_p0 = pad_p0 ? 1'b0 : i_data;

  morph_line_buffer #(.DEPTH(IMG_W + 1)) u_lb1 (
    .i_clk  (i_clk),
    .i_clr  (i_rst),
    .i_en   (adv_p0),
    .i_data (pix_p0),
    .o_data (lb1_p0)
  );

  morph_line_buffer #(.DEPTH(IMG_W + 1)) u_lb2 (
    .i_clk  (i_clk),
    .i_clr  (i_rst),
    .i_en   (adv_p0),
    .i_data (lb1_p0),
    .o_data (lb2_p0)
  );

  // Column entering at (r,c): bit2 row r, bit1 row r-1, bit0 row r-2.
  // With the two stored columns this is the window centered on (r-1,c-1).
  assign col_new_p0 = {pix_p0, lb1_p0, lb2_p0};
  assign win_p0     = {win_a_q, win_b_q, col_new_p0};

  assign vld_p0  = adv_p0 && (row_q != '0) && (col_q != '0);
  assign last_p0 = adv_p0 && row_at_pad && col_at_pad;
  assign res_p0  = filter_op(mode_q, thresh_q, win_p0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_FILL;
      ready_q  <= 1'b1;
      col_q    <= '0;
      row_q    <= '0;
      mode_q   <= MODE_MAJ;
      thresh_q <= DEFAULT_THRESH;
    end else if (adv_p0) begin
      if (col_at_pad) begin
        col_q <= '0;
        row_q <= row_at_pad ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end

      // Mode and threshold are frozen for a whole frame at its first pixel.
      if ((state_q == ST_FILL) && (row_q == '0) && (col_q == '0)) begin
        mode_q   <= mode_e'(i_mode);
        thresh_q <= i_thresh;
      end

      case (state_q)
        ST_FILL, ST_RUN: begin
          if (col_at_last) begin
            state_q <= ST_EOL_PAD;
            ready_q <= 1'b0;
          end else if ((state_q == ST_FILL) && (row_q == ROW_W'(1))) begin
            state_q <= ST_RUN;
          end
        end
        ST_EOL_PAD: begin
          if (row_at_last) begin
            state_q <= ST_EOF_PAD;
          end else begin
            state_q <= (row_q == '0) ? ST_FILL : ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_EOF_PAD: begin
          if (col_at_pad) begin
            state_q <= ST_FILL;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_FILL;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      win_a_q <= '0;
      win_b_q <= '0;
    end else if (adv_p0) begin
      win_a_q <= win_b_q;
      win_b_q <= col_new_p0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: registered outputs
  // ---------------------------------------------------------------------------
  logic vld_p1, data_p1, last_p1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      data_p1 <= vld_p0 ? res_p0 : 1'b0;
      last_p1 <= last_p0;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = vld_p1;
  assign o_data  = data_p1;
  assign o_last  = last_p1;

`ifdef MORPH_FILTER_STATS_EN
  localparam int STATS_W = $clog2(IMG_W*IMG_H+1);

  logic [STATS_W-1:0] ones_acc_q;
  logic [STATS_W-1:0] ones_count_q;

  // The accumulator already includes the final pixel when o_last is shown,
  // so the frame total is published on the following edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ones_acc_q   <= '0;
      ones_count_q <= '0;
    end else if (vld_p1 && last_p1) begin
      ones_count_q <= ones_acc_q;
      ones_acc_q   <= '0;
    end else if (vld_p0 && res_p0) begin
      ones_acc_q <= ones_acc_q + STATS_W'(1);
    end
  end

  assign o_ones_count = ones_count_q;
`endif

endmodule

// File: tb/tb_morph_filter_3x3.sv
// -----------------------------------------------------------------------------
// tb_morph_filter_3x3
// Directed bench for morph_filter_3x3 at IMG_W=8, IMG_H=4.
// Define MORPH_FILTER_STATS_EN to also exercise o_ones_count.
// -----------------------------------------------------------------------------
module tb_morph_filter_3x3;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic       i_data;
  logic [1:0] i_mode;
  logic [3:0] i_thresh;
  logic       o_ready, o_valid, o_data, o_last;
`ifdef MORPH_FILTER_STATS_EN
  logic [5:0] o_ones_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit         stim[0:63];
  logic [1:0] stim_mode[0:63];
  logic [3:0] stim_thr[0:63];
  int         acc_cyc[0:63];
  bit         exp_d[0:31];
  bit         out_d[$];
  bit         out_l[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  morph_filter_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .i_mode   (i_mode),
    .i_thresh (i_thresh),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_last   (o_last)
`ifdef MORPH_FILTER_STATS_EN
    ,
    .o_ones_count (o_ones_count)
`endif
  );

  always @(negedge clk) begin
    if (o_valid) begin
      out_d.push_back(o_data);
      out_l.push_back(o_last);
    end
  end

  task automatic fill(input int first, input int n, input bit v, input logic [1:0] m,
                      input logic [3:0] th);
    for (int i = first; i < first + n; i++) begin
      stim[i] = v; stim_mode[i] = m; stim_thr[i] = th;
    end
  endtask

  task automatic drive(input int n, input bit gaps);
    int idx = 0;
    int budget = 0;
    while (idx < n && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_valid = 1'b0;
      end else begin
        i_valid = 1'b1; i_data = stim[idx]; i_mode = stim_mode[idx]; i_thresh = stim_thr[idx];
        if (o_ready) begin
          acc_cyc[idx] = cyc;
          idx++;
        end
      end
    end
    @(negedge clk);
    i_valid = 1'b0; i_data = 1'b0;
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL drive_accept got=%0d expected=%0d", idx, n);
    end
  endtask

  task automatic wait_out(input int n);
    int b = 0;
    while (out_d.size() < n && b < 300) begin
      @(negedge clk);
      b++;
    end
    repeat (6) @(negedge clk);
  endtask

  // Direct 3x3 evaluation with zero outside the image.
  task automatic model(input int m, input int th);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int pc = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
              if (stim[(r + dr) * W + c + dc]) pc++;
        case (m)
          0: exp_d[r * W + c] = (pc > th);
          1: exp_d[r * W + c] = (pc == 9);
          2: exp_d[r * W + c] = (pc > 0);
          default: exp_d[r * W + c] = stim[r * W + c];
        endcase
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_data = 1'b0; i_mode = 2'd0; i_thresh = 4'd6;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b expected=1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b expected=0", o_valid); end
    checks++; if (o_data !== 1'b0) begin errors++; $display("FAIL reset_data got=%b expected=0", o_data); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b expected=0", o_last); end
`ifdef MORPH_FILTER_STATS_EN
    checks++; if (o_ones_count !== 6'd0) begin errors++; $display("FAIL reset_ones got=%0d expected=0", o_ones_count); end
`endif
  endtask

  // All-ones frame, majority thresh 6: only interior (popcount 9) survives.
  task automatic test_majority();
    fill(0, N, 1'b1, 2'd0, 4'd6);
    out_d.delete(); out_l.delete();
    drive(N, 1'b0);
    wait_out(N);
    checks++; if (out_d.size() != N) begin errors++; $display("FAIL maj_count got=%0d expected=%0d", out_d.size(), N); end
    for (int i = 0; i < out_d.size() && i < N; i++) begin
      bit e;
      e = (i / W >= 1) && (i / W <= 2) && (i % W >= 1) && (i % W <= 6);
      checks++; if (out_d[i] != e) begin errors++; $display("FAIL maj_px%0d got=%b expected=%b", i, out_d[i], e); end
      checks++; if (out_l[i] != (i == N - 1)) begin errors++; $display("FAIL maj_last%0d got=%b expected=%b", i, out_l[i], (i == N - 1)); end
    end
`ifdef MORPH_FILTER_STATS_EN
    checks++; if (o_ones_count !== 6'd12) begin errors++; $display("FAIL maj_ones got=%0d expected=12", o_ones_count); end
`endif
  endtask

  // Single 1 at (2,3): dilate gives the 3x3 block rows 1..3 cols 2..4, erode nothing.
  task automatic test_single_pixel();
    for (int pass = 0; pass < 2; pass++) begin
      fill(0, N, 1'b0, (pass == 0) ? 2'd2 : 2'd1, 4'd6);
      stim[2 * W + 3] = 1'b1;
      out_d.delete(); out_l.delete();
      drive(N, 1'b0);
      wait_out(N);
      checks++; if (out_d.size() != N) begin errors++; $display("FAIL single%0d_count got=%0d expected=%0d", pass, out_d.size(), N); end
      for (int i = 0; i < out_d.size() && i < N; i++) begin
        bit e;
        e = (pass == 0) && (i / W >= 1) && (i / W <= 3) && (i % W >= 2) && (i % W <= 4);
        checks++; if (out_d[i] != e) begin errors++; $display("FAIL single%0d_px%0d got=%b expected=%b", pass, i, out_d[i], e); end
      end
`ifdef MORPH_FILTER_STATS_EN
      checks++; if (o_ones_count !== ((pass == 0) ? 6'd9 : 6'd0)) begin
        errors++; $display("FAIL single%0d_ones got=%0d expected=%0d", pass, o_ones_count, (pass == 0) ? 9 : 0);
      end
`endif
    end
  endtask

  // Two frames with i_valid held high: one pad cycle per row, 1+9 after the
  // last pixel, 45-cycle frame period; bypass output equals input.
  task automatic test_back_to_back();
    for (int i = 0; i < 64; i++) begin
      stim[i] = ((i % 3) == 1) || ((i % 7) == 0); stim_mode[i] = 2'd3; stim_thr[i] = 4'd6;
    end
    out_d.delete(); out_l.delete();
    drive(64, 1'b0);
    wait_out(64);
    for (int k = 1; k < 64; k++) begin
      int e;
      e = (k == 32) ? 11 : ((k % W) == 0) ? 2 : 1;
      checks++; if (acc_cyc[k] - acc_cyc[k - 1] != e) begin
        errors++; $display("FAIL b2b_gap%0d got=%0d expected=%0d", k, acc_cyc[k] - acc_cyc[k - 1], e);
      end
    end
    checks++; if (acc_cyc[32] - acc_cyc[0] != 45) begin errors++; $display("FAIL b2b_period got=%0d expected=45", acc_cyc[32] - acc_cyc[0]); end
    checks++; if (out_d.size() != 64) begin errors++; $display("FAIL b2b_count got=%0d expected=64", out_d.size()); end
    for (int i = 0; i < out_d.size() && i < 64; i++) begin
      checks++; if (out_d[i] != stim[i]) begin errors++; $display("FAIL b2b_px%0d got=%b expected=%b", i, out_d[i], stim[i]); end
    end
  endtask

  task automatic test_bypass_gaps();
    for (int i = 0; i < N; i++) begin
      stim[i] = 1'($urandom_range(0, 1)); stim_mode[i] = 2'd3; stim_thr[i] = 4'd6;
    end
    out_d.delete(); out_l.delete();
    drive(N, 1'b1);
    wait_out(N);
    checks++; if (out_d.size() != N) begin errors++; $display("FAIL gap_count got=%0d expected=%0d", out_d.size(), N); end
    for (int i = 0; i < out_d.size() && i < N; i++) begin
      checks++; if (out_d[i] != stim[i]) begin errors++; $display("FAIL gap_px%0d got=%b expected=%b", i, out_d[i], stim[i]); end
      checks++; if (out_l[i] != (i == N - 1)) begin errors++; $display("FAIL gap_last%0d got=%b expected=%b", i, out_l[i], (i == N - 1)); end
    end
  endtask

  // Mode switches 0->2 at pixel 10: frame 1 stays majority, frame 2 dilates.
  task automatic test_mode_change();
    fill(0, 64, 1'b1, 2'd2, 4'd6);
    for (int i = 0; i < 10; i++) stim_mode[i] = 2'd0;
    out_d.delete(); out_l.delete();
    drive(64, 1'b0);
    wait_out(64);
    checks++; if (out_d.size() != 64) begin errors++; $display("FAIL mode_count got=%0d expected=64", out_d.size()); end
    for (int i = 0; i < out_d.size() && i < 64; i++) begin
      bit e;
      if (i < N) e = (i / W >= 1) && (i / W <= 2) && (i % W >= 1) && (i % W <= 6);
      else       e = 1'b1;
      checks++; if (out_d[i] != e) begin errors++; $display("FAIL mode_px%0d got=%b expected=%b", i, out_d[i], e); end
    end
`ifdef MORPH_FILTER_STATS_EN
    checks++; if (o_ones_count !== 6'd32) begin errors++; $display("FAIL mode_ones got=%0d expected=32", o_ones_count); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int ones;
    fill(0, N, 1'b1, 2'd2, 4'd6);
    drive(17, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b expected=0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b expected=1", o_ready); end
    out_d.delete(); out_l.delete();
    for (int i = 0; i < N; i++) begin
      stim[i] = ((i * 5) % 7) < 3; stim_mode[i] = 2'd0; stim_thr[i] = 4'd3;
    end
    model(0, 3);
    drive(N, 1'b0);
    wait_out(N);
    checks++; if (out_d.size() != N) begin errors++; $display("FAIL rstmid_count got=%0d expected=%0d", out_d.size(), N); end
    ones = 0;
    for (int i = 0; i < N; i++) if (exp_d[i]) ones++;
    for (int i = 0; i < out_d.size() && i < N; i++) begin
      checks++; if (out_d[i] != exp_d[i]) begin errors++; $display("FAIL rstmid_px%0d got=%b expected=%b", i, out_d[i], exp_d[i]); end
      checks++; if (out_l[i] != (i == N - 1)) begin errors++; $display("FAIL rstmid_last%0d got=%b expected=%b", i, out_l[i], (i == N - 1)); end
    end
`ifdef MORPH_FILTER_STATS_EN
    checks++; if (o_ones_count !== 6'(ones)) begin errors++; $display("FAIL rstmid_ones got=%0d expected=%0d", o_ones_count, ones); end
`endif
  endtask

  initial begin
    test_reset();
    test_majority();
    test_single_pixel();
    test_back_to_back();
    test_bypass_gaps();
    test_mode_change();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

endmodule
